float_add_scheduler: RTL and testbench

Round-robin scheduler that shares one pipelined FloatAdd instance among NUM_REQ requesters. Accepts at most one operation per cycle via per-requester valid/ready handshakes, drives the adder operands, tracks each issued operation through the adder's fixed pipeline with a tag shift register, and routes each result back to its originating requester. Sits between FloatAdd and client units such as a vector or accumulate engine; the adder has no valid signal of its own, so this block owns all occupancy tracking.

---
 rtl/float_add_scheduler_pkg.sv | 22 ++
 rtl/float_add_scheduler_if.sv | 53 +++++
 rtl/float_add_scheduler_rr_arbiter.sv | 33 +++
 rtl/float_add_scheduler.sv | 92 +++++++++
 tb/tb_float_add_scheduler.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/float_add_scheduler_pkg.sv
// Shared constants, tag sizing helper and tag-pipeline entry type for the FloatAdd scheduler.
package float_add_scheduler_pkg;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_EXP      = 8;
  localparam int unsigned DEF_FRAC     = 23;
  localparam int unsigned DEF_TRAILING = 2;
  localparam int unsigned DEF_LATENCY  = 3;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned TAG_W = tag_width(DEF_NUM_REQ);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/float_add_scheduler_if.sv
// Requester, adder-pin and response bundle of the FloatAdd scheduler.
interface float_add_scheduler_if
  import float_add_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
  parameter int unsigned EXP           = DEF_EXP,
  parameter int unsigned FRAC          = DEF_FRAC,
  parameter int unsigned TRAILING_BITS = DEF_TRAILING
);
  localparam int unsigned W = 1 + EXP + FRAC;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0][W-1:0] req_a;
  logic [NUM_REQ-1:0][W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_subtract;
  logic                      drain;
  logic                      idle;

  logic [W-1:0]              add_a;
  logic [W-1:0]              add_b;
  logic                      add_subtract;
  logic                      add_reset;
  logic [W-1:0]              add_out;
  logic [TRAILING_BITS-1:0]  add_trailing;
  logic                      add_sticky;
  logic                      add_nan;

  logic [NUM_REQ-1:0]        resp_valid;
  logic [W-1:0]              resp_data;
  logic [TRAILING_BITS-1:0]  resp_trailing;
  logic                      resp_sticky;
  logic                      resp_nan;

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_subtract, drain,
    input  add_out, add_trailing, add_sticky, add_nan,
    output req_ready, idle,
    output add_a, add_b, add_subtract, add_reset,
    output resp_valid, resp_data, resp_trailing, resp_sticky, resp_nan
  );

  // Client and adder side.
  modport master (
    output req_valid, req_a, req_b, req_subtract, drain,
    output add_out, add_trailing, add_sticky, add_nan,
    input  req_ready, idle,
    input  add_a, add_b, add_subtract, add_reset,
    input  resp_valid, resp_data, resp_trailing, resp_sticky, resp_nan
  );

endinterface

// File: rtl/float_add_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or above ptr wins, wrapping.
module rr_arbiter
  import float_add_scheduler_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = tag_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW:0] cand;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[IW'(cand)]) begin
        found                = 1'b1;
        grant[IW'(cand)]     = 1'b1;
        grant_idx            = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/float_add_scheduler.sv
// Shares one pipelined FloatAdd among NUM_REQ requesters; tags track each op back to its issuer.
module float_add_scheduler
  import float_add_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
  parameter int unsigned EXP           = DEF_EXP,
  parameter int unsigned FRAC          = DEF_FRAC,
  parameter int unsigned TRAILING_BITS = DEF_TRAILING,
  parameter int unsigned LATENCY       = DEF_LATENCY
) (
  input logic                  clock,
  input logic                  reset,
  float_add_scheduler_if.slave bus
);

  localparam int unsigned TW = tag_width(NUM_REQ);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  logic [TW-1:0]      ptr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [TW-1:0]      grant_idx;
  logic               handshake;
  logic               resp_fire;
  logic [NUM_REQ-1:0] resp_strobe;
  logic [CW-1:0]      inflight;
  tag_entry_t         stages [LATENCY];

  assign eligible = (reset && !bus.drain) ? bus.req_valid : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is only ever raised on a valid requester, so any grant is a handshake.
  assign handshake     = |grant;
  assign bus.req_ready = grant;

  assign bus.add_a        = handshake ? bus.req_a[grant_idx] : '0;
  assign bus.add_b        = handshake ? bus.req_b[grant_idx] : '0;
  assign bus.add_subtract = handshake ? bus.req_subtract[grant_idx] : 1'b0;
  assign bus.add_reset    = !reset;

  // Responses still in the pipe during a reset cycle are discarded.
  assign resp_fire = reset && stages[LATENCY-1].valid;

  always_comb begin
    resp_strobe = '0;
    if (resp_fire) resp_strobe[stages[LATENCY-1].tag] = 1'b1;
  end

  assign bus.resp_valid    = resp_strobe;
  assign bus.resp_data     = bus.add_out;
  assign bus.resp_trailing = bus.add_trailing;
  assign bus.resp_sticky   = bus.add_sticky;
  assign bus.resp_nan      = bus.add_nan;
  assign bus.idle          = !reset || (inflight == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= (grant_idx == TW'(NUM_REQ - 1)) ? '0 : grant_idx + TW'(1);
    end
  end

  // Tag pipeline mirrors the adder's fixed depth.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) stages[i] <= '0;
    end else begin
      stages[0] <= '{valid: handshake, tag: TAG_W'(grant_idx)};
      for (int unsigned i = 1; i < LATENCY; i++) stages[i] <= stages[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      inflight <= '0;
    end else begin
      case ({handshake, resp_fire})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_float_add_scheduler.sv
// Directed bench for float_add_scheduler with a table-driven stand-in for the 3-stage FloatAdd.
module tb_float_add_scheduler;
  import float_add_scheduler_pkg::*;

  localparam int unsigned W = 1 + DEF_EXP + DEF_FRAC;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  float_add_scheduler_if bus ();

  float_add_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Known float sums used by the vectors; anything else returns a poison value.
  function automatic logic [W-1:0] fake_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    case ({s, a, b})
      {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000;
      {1'b1, 32'h40800000, 32'h3F800000}: return 32'h40400000;
      {1'b1, 32'h7F800000, 32'h7F800000}: return 32'h7FC00000;
      {1'b0, 32'h00000000, 32'h00000000}: return 32'h00000000;
      default:                            return 32'hDEADBEEF;
    endcase
  endfunction

  logic [W-1:0] p_sum [3];
  logic         p_sub [3];

  always @(posedge clock) begin
    if (bus.add_reset) begin
      for (int i = 0; i < 3; i++) begin
        p_sum[i] <= '0;
        p_sub[i] <= 1'b0;
      end
    end else begin
      p_sum[0] <= fake_sum(bus.add_a, bus.add_b, bus.add_subtract);
      p_sub[0] <= bus.add_subtract;
      for (int i = 1; i < 3; i++) begin
        p_sum[i] <= p_sum[i-1];
        p_sub[i] <= p_sub[i-1];
      end
    end
  end

  assign bus.add_out      = p_sum[2];
  assign bus.add_nan      = (p_sum[2] == 32'h7FC00000);
  assign bus.add_trailing = {p_sub[2], 1'b1};
  assign bus.add_sticky   = p_sub[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req_valid = '0;
    bus.drain = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  logic [31:0] ctn_res [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40400000};
  logic [31:0] exp_rv;

  initial begin
    bus.req_valid    = '0;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.req_subtract = '0;
    bus.drain        = 1'b0;

    // Reset state, with requests present to confirm reset blocks eligibility.
    tick();
    bus.req_valid = '1;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_resp", 32'(bus.resp_valid), 32'h0);
    check("rst_idle", 32'(bus.idle), 32'h1);
    check("rst_add_a", bus.add_a, 32'h0);
    check("rst_add_reset", 32'(bus.add_reset), 32'h1);
    tick();
    reset = 1'b1;
    bus.req_valid = '0;
    tick();
    #1;
    check("post_rst_idle", 32'(bus.idle), 32'h1);
    check("post_rst_add_reset", 32'(bus.add_reset), 32'h0);

    // Single op from requester 1: 1.0 + 2.0 = 3.0.
    bus.req_valid = 4'b0010;
    bus.req_a[1] = 32'h3F800000;
    bus.req_b[1] = 32'h40000000;
    bus.req_subtract[1] = 1'b0;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h2);
    check("single_add_a", bus.add_a, 32'h3F800000);
    check("single_add_b", bus.add_b, 32'h40000000);
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus.req_valid = '0;
      #1;
      if (k < 3) begin
        check("single_no_resp", 32'(bus.resp_valid), 32'h0);
      end else begin
        check("single_resp", 32'(bus.resp_valid), 32'h2);
        check("single_data", bus.resp_data, 32'h40400000);
        check("single_trailing", 32'(bus.resp_trailing), 32'h1);
        check("single_idle_busy", 32'(bus.idle), 32'h0);
      end
    end
    tick();
    #1;
    check("single_idle_after", 32'(bus.idle), 32'h1);

    // Contention: all four valid for 8 cycles from pointer 0.
    do_reset();
    bus.req_a[0] = 32'h3F800000; bus.req_b[0] = 32'h3F800000; bus.req_subtract[0] = 1'b0;
    bus.req_a[1] = 32'h3F800000; bus.req_b[1] = 32'h40000000; bus.req_subtract[1] = 1'b0;
    bus.req_a[2] = 32'h40000000; bus.req_b[2] = 32'h40000000; bus.req_subtract[2] = 1'b0;
    bus.req_a[3] = 32'h40800000; bus.req_b[3] = 32'h3F800000; bus.req_subtract[3] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) check($sformatf("ctn_grant%0d", k), 32'(bus.req_ready), 32'(1) << (k % 4));
      exp_rv = (k >= 3) ? (32'(1) << ((k - 3) % 4)) : 32'h0;
      check($sformatf("ctn_resp%0d", k), 32'(bus.resp_valid), exp_rv);
      if (k >= 3) check($sformatf("ctn_data%0d", k), bus.resp_data, ctn_res[(k - 3) % 4]);
      if (k >= 1) check($sformatf("ctn_idle%0d", k), 32'(bus.idle), 32'h0);
    end
    tick();
    #1;
    check("ctn_quiet", 32'(bus.resp_valid), 32'h0);
    check("ctn_idle_end", 32'(bus.idle), 32'h1);

    // Subtract producing NaN: inf - inf from requester 3.
    bus.req_valid = 4'b1000;
    bus.req_a[3] = 32'h7F800000;
    bus.req_b[3] = 32'h7F800000;
    bus.req_subtract[3] = 1'b1;
    #1;
    check("nan_ready", 32'(bus.req_ready), 32'h8);
    check("nan_sub", 32'(bus.add_subtract), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus.req_valid = '0;
      #1;
      if (k == 3) begin
        check("nan_resp", 32'(bus.resp_valid), 32'h8);
        check("nan_flag", 32'(bus.resp_nan), 32'h1);
        check("nan_data", bus.resp_data, 32'h7FC00000);
        check("nan_sticky", 32'(bus.resp_sticky), 32'h1);
        check("nan_trailing", 32'(bus.resp_trailing), 32'h3);
      end
    end
    tick();

    // Drain from cycle 2 with all requesters valid; pointer is back at 0.
    bus.req_a[3] = 32'h40800000; bus.req_b[3] = 32'h3F800000;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      bus.req_valid = 4'b1111;
      bus.drain = (k >= 2);
      #1;
      if (k < 2) check($sformatf("drain_grant%0d", k), 32'(bus.req_ready), 32'(1) << k);
      else       check($sformatf("drain_block%0d", k), 32'(bus.req_ready), 32'h0);
      if (k == 2) check("drain_add_a", bus.add_a, 32'h0);
      if (k == 3) begin
        check("drain_resp0", 32'(bus.resp_valid), 32'h1);
        check("drain_data0", bus.resp_data, 32'h40000000);
      end
      if (k == 4) begin
        check("drain_resp1", 32'(bus.resp_valid), 32'h2);
        check("drain_data1", bus.resp_data, 32'h40400000);
        check("drain_idle4", 32'(bus.idle), 32'h0);
      end
      if (k == 5) begin
        check("drain_resp5", 32'(bus.resp_valid), 32'h0);
        check("drain_idle5", 32'(bus.idle), 32'h1);
      end
    end
    bus.req_valid = '0;
    bus.drain = 1'b0;

    // Reset mid-flight: pointer is 2, so requesters 0 then 1 win, then one reset cycle.
    tick();
    bus.req_valid = 4'b0011;
    #1;
    check("rmf_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    #1;
    check("rmf_grant1", 32'(bus.req_ready), 32'h2);
    tick();
    reset = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    check("rmf_add_reset", 32'(bus.add_reset), 32'h1);
    check("rmf_ready_rst", 32'(bus.req_ready), 32'h0);
    check("rmf_resp_rst", 32'(bus.resp_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      reset = 1'b1;
      bus.req_valid = '0;
      #1;
      check($sformatf("rmf_no_resp%0d", k), 32'(bus.resp_valid), 32'h0);
      check($sformatf("rmf_idle%0d", k), 32'(bus.idle), 32'h1);
    end
    bus.req_valid = 4'b1111;
    #1;
    check("rmf_ptr0", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;

    // Back-to-back from requester 2 only.
    bus.req_a[2] = 32'h3F800000;
    bus.req_b[2] = 32'h40000000;
    bus.req_subtract[2] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      bus.req_valid = (k < 5) ? 4'b0100 : 4'b0000;
      #1;
      if (k < 5) check($sformatf("b2b_grant%0d", k), 32'(bus.req_ready), 32'h4);
      exp_rv = (k >= 3 && k < 8) ? 32'h4 : 32'h0;
      check($sformatf("b2b_resp%0d", k), 32'(bus.resp_valid), exp_rv);
      if (k >= 3 && k < 8) check($sformatf("b2b_data%0d", k), bus.resp_data, 32'h40400000);
    end
    check("b2b_idle_end", 32'(bus.idle), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
